// File: rtl/sma_window_ctrl_pkg.sv
// Shared types and helpers for the SMA window controller.
package sma_pkg;

    typedef enum logic [1:0] {EMPTY, FILL, FULL} sma_state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_LOG2_WIN = 2;
    localparam int MAX_LOG2_WIN = 5;

    // One-hot decode sized for the deepest supported window; callers truncate.
    function automatic logic [(2**MAX_LOG2_WIN)-1:0] onehot(input logic [MAX_LOG2_WIN-1:0] idx);
        logic [(2**MAX_LOG2_WIN)-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sma_window_ctrl_ptr_counter.sv
// Modulo-2**W wrapping slot pointer with enable and synchronous active-low reset.
module sma_ptr_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    // Natural W-bit overflow provides the WINDOW-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (!reset || clr)
            ptr <= '0;
        else if (en)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/sma_window_ctrl.sv
// Moving-average window controller driving an external circular register bank.
// Optional synchronous window clear enabled with `define SMA_FLUSH_EN (adds port flush).
module sma_window_ctrl
    import sma_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOG2_WIN = DEF_LOG2_WIN
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef SMA_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_price,
    output logic [2**LOG2_WIN-1:0] bank_en,
    output logic [WIDTH-1:0]       bank_din,
    output logic [LOG2_WIN-1:0]    bank_sel,
    input  logic [WIDTH-1:0]       bank_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_avg,
    output logic                   out_full
);

    localparam int WINDOW = 2**LOG2_WIN;
    localparam int SUM_W  = WIDTH + LOG2_WIN;
    localparam int CNT_W  = LOG2_WIN + 1;

    function automatic logic [WIDTH-1:0] avg_trunc(input logic [SUM_W-1:0] s);
        return WIDTH'(s >> LOG2_WIN);
    endfunction

    logic                flush_i;
    logic                accept;
    logic                fill_full;
    logic [WIDTH-1:0]    evicted;
    logic [SUM_W-1:0]    sum_d;
    logic [SUM_W-1:0]    sum_p1;
    logic [CNT_W-1:0]    count_d;
    logic [CNT_W-1:0]    count_p1;
    logic [LOG2_WIN-1:0] wr_ptr;
    sma_state_t          state_d;
    sma_state_t          state_p1;

`ifdef SMA_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    sma_ptr_counter #(.W(LOG2_WIN)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .en    (accept),
        .ptr   (wr_ptr)
    );

    assign bank_din = in_price;
    assign bank_sel = wr_ptr;

    // Stage p0: handshake, slot select and running-sum update
    always_comb begin
        in_ready = ~(out_valid & ~out_ready) & ~flush_i;
        accept   = in_valid & in_ready;
        bank_en  = accept ? WINDOW'(onehot(MAX_LOG2_WIN'(wr_ptr))) : '0;
        evicted  = (state_p1 == FULL) ? bank_rdata : '0;
        sum_d    = sum_p1 + SUM_W'(in_price) - SUM_W'(evicted);
    end

    always_comb begin
        state_d = state_p1;
        count_d = count_p1;
        if (accept) begin
            case (state_p1)
                EMPTY: begin
                    state_d = FILL;
                    count_d = CNT_W'(1);
                end
                FILL: begin
                    count_d = count_p1 + 1'b1;
                    if (count_p1 == CNT_W'(WINDOW - 1))
                        state_d = FULL;
                end
                default: ;
            endcase
        end
    end

    assign fill_full = accept && (state_d == FULL);

    // Stage p1: window state and registered sum
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            state_p1 <= EMPTY;
            count_p1 <= '0;
            sum_p1   <= '0;
        end else begin
            state_p1 <= state_d;
            count_p1 <= count_d;
            if (accept)
                sum_p1 <= sum_d;
        end
    end

    // Single-entry output stage; a new average overwrites a pending one
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_avg   <= '0;
            out_full  <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            out_full  <= 1'b0;
        end else begin
            out_full <= (state_d == FULL);
            if (fill_full) begin
                out_valid <= 1'b1;
                out_avg   <= avg_trunc(sum_d);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sma_window_ctrl.sv
// Self-checking bench for sma_window_ctrl: directed table, corner sequences, random traffic.
module tb_sma_window_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fl;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_price;
    logic [3:0]  bank_en;
    logic [15:0] bank_din;
    logic [1:0]  bank_sel;
    logic [15:0] bank_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_avg;
    logic        out_full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sma_window_ctrl #(.WIDTH(16), .LOG2_WIN(2)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SMA_FLUSH_EN
        .flush      (fl),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_price   (in_price),
        .bank_en    (bank_en),
        .bank_din   (bank_din),
        .bank_sel   (bank_sel),
        .bank_rdata (bank_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_avg    (out_avg),
        .out_full   (out_full)
    );

    // External register bank
    logic [15:0] bank [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bank_en[i]) bank[i] <= bank_din;
    end
    assign bank_rdata = bank[bank_sel];

    // Reference model: the last four accepted samples and the pending output
    int unsigned win[$];
    int          m_ptr;
    logic        m_ov;
    logic [15:0] m_avg;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input logic clr_avg);
        win.delete();
        m_ptr = 0;
        m_ov  = 1'b0;
        if (clr_avg) m_avg = '0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs
    task automatic cycle(input logic v, input logic [15:0] p, input logic r, input logic f);
        logic        exp_rdy;
        logic        acc;
        int unsigned s;
        in_valid  = v;
        in_price  = p;
        out_ready = r;
        fl        = f;
        #2;
        exp_rdy = !(m_ov && !r) && !f;
        acc     = v && exp_rdy;
        check("in_ready", in_ready, exp_rdy);
        check("bank_en", bank_en, acc ? (1 << m_ptr) : 0);
        check("bank_din", bank_din, p);
        if (f) begin
            model_clear(1'b0);
        end else if (acc) begin
            win.push_back(p);
            if (win.size() > 4) void'(win.pop_front());
            m_ptr = (m_ptr + 1) % 4;
            if (win.size() == 4) begin
                s = 0;
                foreach (win[i]) s += win[i];
                m_ov  = 1'b1;
                m_avg = 16'(s / 4);
            end else if (r) begin
                m_ov = 1'b0;
            end
        end else if (r) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        check("out_avg", out_avg, m_avg);
        check("out_full", out_full, win.size() == 4);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        fl       = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear(1'b1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_avg", out_avg, 0);
        check("rst_out_full", out_full, 0);
        check("rst_bank_en", bank_en, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] p;
        logic        r;
        logic [3:0]  en;
        logic        ov;
        logic [15:0] avg;
    } vec_t;

    vec_t tbl[7];

    initial begin
        reset     = 1'b1;
        fl        = 1'b0;
        in_valid  = 1'b0;
        in_price  = '0;
        out_ready = 1'b1;
        m_avg     = '0;
        model_clear(1'b1);

        tbl[0] = '{1'b1, 16'd10, 1'b1, 4'b0001, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 16'd20, 1'b1, 4'b0010, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 16'd30, 1'b1, 4'b0100, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 16'd40, 1'b1, 4'b1000, 1'b1, 16'd25};
        tbl[4] = '{1'b1, 16'd50, 1'b1, 4'b0001, 1'b1, 16'd35};
        tbl[5] = '{1'b1, 16'd60, 1'b1, 4'b0010, 1'b1, 16'd45};
        tbl[6] = '{1'b0, 16'd0,  1'b1, 4'b0000, 1'b0, 16'd45};

        @(posedge clk);
        do_reset();

        // Directed fill, first averages and wrap
        for (int i = 0; i < 7; i++) begin
            in_valid  = tbl[i].v;
            in_price  = tbl[i].p;
            out_ready = tbl[i].r;
            #1;
            check($sformatf("tbl%0d_bank_en", i), bank_en, tbl[i].en);
            cycle(tbl[i].v, tbl[i].p, tbl[i].r, 1'b0);
            check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d_out_avg", i), out_avg, tbl[i].avg);
        end

        // Backpressure: pending average blocks input until released
        cycle(1'b1, 16'd70, 1'b0, 1'b0);
        check("bp_avg_first", out_avg, 55);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'd80, 1'b0, 1'b0);
            check("bp_avg_hold", out_avg, 55);
        end
        cycle(1'b1, 16'd80, 1'b1, 1'b0);
        check("bp_release_avg", out_avg, 65);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);

        // Full-scale samples must not overflow the sum
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("max_avg", out_avg, 16'hFFFF);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);

        // Reset mid-fill discards the partial window
        do_reset();
        cycle(1'b1, 16'd7, 1'b1, 1'b0);
        cycle(1'b1, 16'd9, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 16'd1, 1'b1, 1'b0);
        cycle(1'b1, 16'd2, 1'b1, 1'b0);
        cycle(1'b1, 16'd3, 1'b1, 1'b0);
        check("post_rst_not_full", out_full, 0);
        cycle(1'b1, 16'd6, 1'b1, 1'b0);
        check("post_rst_avg", out_avg, 3);
        check("post_rst_valid", out_valid, 1);

`ifdef SMA_FLUSH_EN
        // Flush drops the concurrent sample and restarts the fill
        cycle(1'b1, 16'd100, 1'b1, 1'b1);
        check("flush_full", out_full, 0);
        check("flush_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(4 * (i + 1)), 1'b1, 1'b0);
        check("flush_refill_pending", out_valid, 0);
        cycle(1'b1, 16'd16, 1'b1, 1'b0);
        check("flush_refill_avg", out_avg, 10);
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'b0);
            if ($urandom_range(0, 150) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sma_window_ctrl.md
Name: sma_window_ctrl

Overview:
- Controller for the SMA sample window.
- Sequences an external bank of WINDOW enabled D-flip-flop registers as a circular buffer and drives a one-hot write enable per slot.
- Keeps the running sum: adds each new sample and subtracts the evicted one.
- Emits the moving average once the window is full. Sits between the market-data price feed and the trading-signal logic.

Parameters:
- WIDTH, 16, price sample width in bits.
- LOG2_WIN, 2, log2 of the window depth. WINDOW = 2**LOG2_WIN, must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- in_valid  input  1  new price sample presented.
- in_ready  output  1  controller can accept a sample this cycle.
- in_price  input  WIDTH  new price sample.
- bank_en  output  WINDOW  one-hot write enable to the register bank. Bit i loads slot i.
- bank_din  output  WIDTH  data to the bank. Always equals in_price (combinational).
- bank_sel  output  LOG2_WIN  slot index read back. Always equals wr_ptr.
- bank_rdata  input  WIDTH  current contents of slot bank_sel, combinational from the bank.
- out_valid  output  1  average valid.
- out_ready  input  1  consumer accepts the average.
- out_avg  output  WIDTH  sum >> LOG2_WIN (truncating).
- out_full  output  1  window holds WINDOW valid samples.

Behaviour:
- Reset (reset==0 at a clk edge): wr_ptr=0, count=0, sum=0, state=EMPTY.
  - Outputs after reset: out_valid=0, out_avg=0, out_full=0, bank_en=0.
  - Bank contents are not cleared; the controller ignores them until overwritten.
  - Reset mid-operation discards the window and any pending output, with no handshake.
- Accept: accept = in_valid & in_ready.
  - in_ready = ~(out_valid & ~out_ready), i.e. single-entry output stage with backpressure.
  - in_ready is combinational from out_valid and out_ready only; it never depends on in_valid.
- On accept (all in the same cycle):
  - bank_en = one-hot(wr_ptr), otherwise 0.
  - evicted = bank_rdata if state==FULL, else 0.
  - Registered sum_next = sum + in_price − evicted.
  - wr_ptr increments modulo WINDOW, wrapping from WINDOW−1 to 0.
- Sum width: WIDTH+LOG2_WIN bits, unsigned. It cannot overflow because every sample is < 2**WIDTH.
- States:
  - EMPTY (count=0) → FILL on accept.
  - FILL (0<count<WINDOW): count++ on each accept. When count reaches WINDOW, go to FULL.
  - FULL: count holds at WINDOW; no exit except reset.
- Output stage:
  - On an accept that leaves state==FULL (including the filling accept), next cycle out_valid=1 and out_avg=sum_next>>LOG2_WIN.
  - out_valid clears on out_ready when no new FULL accept occurs in the same cycle.
  - Simultaneous out_ready and accept: the new average replaces the old one, out_valid stays 1.
  - Latency is 1 cycle from accept to out_valid.
  - out_avg holds its value while out_valid & ~out_ready.
- out_full = (state==FULL), registered.
- in_valid with in_ready=0: no state change and bank_en=0. The sample must be held by the producer.

Optional Feature:
- Macro: SMA_FLUSH_EN.
- When defined, adds input port flush (1 bit).
  - flush=1 at a clk edge: wr_ptr, count and sum go to 0, state=EMPTY, out_valid=0 and out_full=0. An accept in the same cycle is dropped.
  - in_ready=0 while flush=1.
  - flush has priority below reset and above accept.
- When undefined: no flush port; only reset clears the window.

Decomposition:
- Shared package sma_pkg holds:
  - typedef enum sma_state_t {EMPTY, FILL, FULL};
  - default WIDTH/LOG2_WIN localparams;
  - function onehot(idx).
- One sub-module: sma_ptr_counter, a modulo-WINDOW wrapping pointer with enable and synchronous active-low reset.
- The register bank stays external, built from the existing enabled flip-flop register.

Test Plan (WIDTH=16, LOG2_WIN=2):
- Reset, then feed 10, 20, 30, 40 with out_ready=1 → out_valid first high 1 cycle after the 4th accept, out_avg=25. bank_en sequence 0001, 0010, 0100, 1000.
- Continue with 50, 60 → out_avg 35 then 45. bank_en wraps to 0001 then 0010. Evicted values are 10 and 20.
- Hold out_ready=0 after an average is produced → in_ready=0, further in_valid is ignored, bank_en=0, out_avg is stable. Releasing out_ready resumes operation with no lost or duplicated sample.
- Feed 0xFFFF ×4 → sum=0x3FFFC with no overflow, out_avg=0xFFFF.
- Assert reset low for one cycle after 2 of 4 samples → all outputs reset. The next 4 samples 1, 2, 3, 6 give out_avg=3.
- SMA_FLUSH_EN: assert flush together with in_valid once the window is full → sample dropped, out_full=0, and the next full window needs 4 new accepts.
